// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT datapath and its frame controller.
//   FRACTION          : number of fractional bits in samples/bins (Q.8)
//   SAMPLE_W          : default sample width
//   sample_t          : signed sample/bin word of the default width
//   fft_ctrl_state_e  : frame controller phases
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FRACTION = 8;
    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } fft_ctrl_state_e;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl_if
// Sample-in and bin-out streams of the FFT frame controller.
//   in_valid/in_ready/in_real/in_im                 : sample stream into the controller
//   out_valid/out_ready/out_real/out_im/out_index/out_last : bin stream out of it
// Handshake: a word moves on a rising clk edge where valid && ready are both
// high. Once valid is raised the sender holds valid and data unchanged until
// that transfer happens; ready may change freely and never depends
// combinationally on valid.
// Modports:
//   slave  : the controller (consumes samples, produces bins)
//   master : the environment (produces samples, consumes bins)
// ---------------------------------------------------------------------------
interface fft_frame_ctrl_if #(
    parameter int W      = 16,
    parameter int STAGES = 4
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_real;
    logic signed [W-1:0] in_im;

    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_real;
    logic signed [W-1:0] out_im;
    logic [STAGES-1:0]   out_index;
    logic                out_last;

    modport slave (
        input  in_valid, in_real, in_im, out_ready,
        output in_ready, out_valid, out_real, out_im, out_index, out_last
    );

    modport master (
        output in_valid, in_real, in_im, out_ready,
        input  in_ready, out_valid, out_real, out_im, out_index, out_last
    );
endinterface

// File: rtl/fft_frame_buf.sv
// ---------------------------------------------------------------------------
// fft_frame_buf
// N-entry complex register array with full parallel read.
//   clk, rst            : clock, asynchronous active-high clear
//   wr_en/wr_idx/wr_*   : single-slot indexed write
//   load_all/ld_*       : overwrite every slot at once (wins over wr_en)
//   rd_real/rd_im       : all slots, always visible
// ---------------------------------------------------------------------------
module fft_frame_buf #(
    parameter int N      = 16,
    parameter int W      = 16,
    parameter int STAGES = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [STAGES-1:0]   wr_idx,
    input  logic signed [W-1:0] wr_real,
    input  logic signed [W-1:0] wr_im,
    input  logic                load_all,
    input  logic signed [W-1:0] ld_real [0:N-1],
    input  logic signed [W-1:0] ld_im   [0:N-1],
    output logic signed [W-1:0] rd_real [0:N-1],
    output logic signed [W-1:0] rd_im   [0:N-1]
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                rd_real[i] <= '0;
                rd_im[i]   <= '0;
            end
        end else if (load_all) begin
            for (int i = 0; i < N; i++) begin
                rd_real[i] <= ld_real[i];
                rd_im[i]   <= ld_im[i];
            end
        end else if (wr_en) begin
            rd_real[wr_idx] <= wr_real;
            rd_im[wr_idx]   <= wr_im;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl
// Frame sequencer for an external N-point FFT core. Collects N samples,
// holds them on the core inputs for FFT_LAT cycles, captures the parallel
// result and streams the bins out in natural order.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   bus (slave)        : sample-in / bin-out valid/ready streams
//   busy               : high while computing or unloading
//   frames_done        : completed-frame counter, wraps at 16 bits
//   fft_x_real/_im     : input buffer, wired to the core inputs
//   fft_X_real/_im     : core outputs, captured into the output buffer
//   state_dbg          : current controller phase
// Build option: define FFT_FRAME_CTRL_SCALE_EN to normalise bins by 1/N
// (round half up) as they are captured.
// ---------------------------------------------------------------------------
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int N       = 16,
    parameter int W       = 16,
    parameter int STAGES  = $clog2(N),
    parameter int FFT_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    fft_frame_ctrl_if.slave     bus,
    output logic                busy,
    output logic [15:0]         frames_done,
    output logic signed [W-1:0] fft_x_real [0:N-1],
    output logic signed [W-1:0] fft_x_im   [0:N-1],
    input  logic signed [W-1:0] fft_X_real [0:N-1],
    input  logic signed [W-1:0] fft_X_im   [0:N-1],
    output fft_ctrl_state_e     state_dbg
);

    localparam int LAT_W = (FFT_LAT > 0) ? $clog2(FFT_LAT + 1) : 1;
    localparam logic [STAGES-1:0] LAST_IDX = STAGES'(N - 1);

    fft_ctrl_state_e     state;
    logic [STAGES-1:0]   load_cnt;
    logic [STAGES-1:0]   out_cnt;
    logic [LAT_W-1:0]    lat_cnt;
    logic                in_ready_q;
    logic                out_valid_q;

    logic                in_accept;
    logic                out_xfer;
    logic                capture;

    logic signed [W-1:0] cap_real [0:N-1];
    logic signed [W-1:0] cap_im   [0:N-1];
    logic signed [W-1:0] obuf_real [0:N-1];
    logic signed [W-1:0] obuf_im   [0:N-1];

    // in_ready is only ever high in LOAD, so no extra state qualifier needed.
    assign in_accept = bus.in_valid && in_ready_q;
    assign out_xfer  = out_valid_q && bus.out_ready;
    assign capture   = (state == COMPUTE) && (lat_cnt == '0);

`ifdef FFT_FRAME_CTRL_SCALE_EN
    // (bin + N/2) >>> log2(N) in W+1 bits so the rounding offset cannot
    // overflow before the shift.
    function automatic logic signed [W-1:0] scale_bin(input logic signed [W-1:0] b);
        logic signed [W:0] ext;
        ext = {b[W-1], b} + (W+1)'(2 ** (STAGES - 1));
        return W'(ext >>> STAGES);
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < N; i++) begin
`ifdef FFT_FRAME_CTRL_SCALE_EN
            cap_real[i] = scale_bin(fft_X_real[i]);
            cap_im[i]   = scale_bin(fft_X_im[i]);
`else
            cap_real[i] = fft_X_real[i];
            cap_im[i]   = fft_X_im[i];
`endif
        end
    end

    // Input buffer: filled one slot per accepted sample, never cleared
    // between frames, and read in parallel by the core.
    fft_frame_buf #(.N(N), .W(W), .STAGES(STAGES)) u_in_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (in_accept),
        .wr_idx   (load_cnt),
        .wr_real  (bus.in_real),
        .wr_im    (bus.in_im),
        .load_all (1'b0),
        .ld_real  (fft_X_real),
        .ld_im    (fft_X_im),
        .rd_real  (fft_x_real),
        .rd_im    (fft_x_im)
    );

    // Output buffer: loaded in one shot with the core result.
    fft_frame_buf #(.N(N), .W(W), .STAGES(STAGES)) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (1'b0),
        .wr_idx   ('0),
        .wr_real  ('0),
        .wr_im    ('0),
        .load_all (capture),
        .ld_real  (cap_real),
        .ld_im    (cap_im),
        .rd_real  (obuf_real),
        .rd_im    (obuf_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            load_cnt    <= '0;
            out_cnt     <= '0;
            lat_cnt     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            frames_done <= '0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready_q <= 1'b1;
                    if (in_accept) begin
                        if (load_cnt == LAST_IDX) begin
                            load_cnt   <= '0;
                            lat_cnt    <= LAT_W'(FFT_LAT);
                            in_ready_q <= 1'b0;
                            busy       <= 1'b1;
                            state      <= COMPUTE;
                        end else begin
                            load_cnt <= load_cnt + STAGES'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (lat_cnt == '0) begin
                        out_cnt     <= '0;
                        out_valid_q <= 1'b1;
                        state       <= UNLOAD;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                UNLOAD: begin
                    if (out_xfer) begin
                        if (out_cnt == LAST_IDX) begin
                            out_cnt     <= '0;
                            out_valid_q <= 1'b0;
                            busy        <= 1'b0;
                            in_ready_q  <= 1'b1;
                            frames_done <= frames_done + 16'd1;
                            state       <= LOAD;
                        end else begin
                            out_cnt <= out_cnt + STAGES'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Bin outputs are a register-indexed mux of the output buffer; they move
    // only when out_cnt advances, so they stay put while the sink stalls.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_real  = obuf_real[out_cnt];
    assign bus.out_im    = obuf_im[out_cnt];
    assign bus.out_index = out_cnt;
    assign bus.out_last  = out_valid_q && (out_cnt == LAST_IDX);
    assign state_dbg     = state;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_ctrl
// Drives sample frames into fft_frame_ctrl, stands in for the FFT core with a
// pipelined DFT, and checks every bin against a frame-level reference model.
// Honours FFT_FRAME_CTRL_SCALE_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    localparam int N       = 16;
    localparam int W       = 16;
    localparam int STAGES  = 4;
    localparam int FFT_LAT = 2;
    localparam int EXP_W   = 1 + STAGES + 2 * W;
    localparam int LIMIT   = 2000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    fft_frame_ctrl_if #(.W(W), .STAGES(STAGES)) bus ();

    logic                busy;
    logic [15:0]         frames_done;
    fft_ctrl_state_e     state_dbg;
    logic signed [W-1:0] fft_x_real [0:N-1];
    logic signed [W-1:0] fft_x_im   [0:N-1];
    logic signed [W-1:0] fft_X_real [0:N-1];
    logic signed [W-1:0] fft_X_im   [0:N-1];

    fft_frame_ctrl #(.N(N), .W(W), .STAGES(STAGES), .FFT_LAT(FFT_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .frames_done (frames_done),
        .fft_x_real  (fft_x_real),
        .fft_x_im    (fft_x_im),
        .fft_X_real  (fft_X_real),
        .fft_X_im    (fft_X_im),
        .state_dbg   (state_dbg)
    );

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- DFT reference (Q14 twiddles) ----------------
    function automatic int tw(input int m, input bit sine);
        real a, r;
        a = 2.0 * 3.14159265358979 * real'(m) / real'(N);
        r = (sine ? $sin(a) : $cos(a)) * 16384.0;
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // X[k] = sum x[n] * e^{-j 2 pi n k / N}
    function automatic int dft_bin(input logic signed [W-1:0] xr [0:N-1],
                                   input logic signed [W-1:0] xi [0:N-1],
                                   input int k, input bit im_part);
        longint acc;
        int     m, c, s;
        acc = 0;
        for (int n = 0; n < N; n++) begin
            m = (n * k) % N;
            c = tw(m, 1'b0);
            s = tw(m, 1'b1);
            if (!im_part) acc += longint'(xr[n]) * c + longint'(xi[n]) * s;
            else          acc += longint'(xi[n]) * c - longint'(xr[n]) * s;
        end
        return int'((acc + 64'sd8192) >>> 14);
    endfunction

    function automatic int scale_ref(input int b);
`ifdef FFT_FRAME_CTRL_SCALE_EN
        return (b + N / 2) >>> STAGES;
`else
        return b;
`endif
    endfunction

    // Core stand-in: result is valid FFT_LAT (=2) edges after its inputs settle.
    logic signed [W-1:0] p1_re [0:N-1];
    logic signed [W-1:0] p1_im [0:N-1];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            p1_re[k]      <= W'(dft_bin(fft_x_real, fft_x_im, k, 1'b0));
            p1_im[k]      <= W'(dft_bin(fft_x_real, fft_x_im, k, 1'b1));
            fft_X_real[k] <= p1_re[k];
            fft_X_im[k]   <= p1_im[k];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [EXP_W-1:0]    exp_q [$];
    logic signed [W-1:0] fr_re [$];
    logic signed [W-1:0] fr_im [$];
    int m_frames     = 0;
    bit m_started    = 1'b0;
    int m_out_start  = 0;
    int m_last_xfer  = -10;
    int n_xfer       = 0;
    int last_bin0    = 0;

    task automatic build_expected();
        logic signed [W-1:0] xr [0:N-1];
        logic signed [W-1:0] xi [0:N-1];
        logic signed [W-1:0] br, bi;
        for (int n = 0; n < N; n++) begin
            xr[n] = fr_re[n];
            xi[n] = fr_im[n];
        end
        for (int k = 0; k < N; k++) begin
            br = W'(dft_bin(xr, xi, k, 1'b0));
            bi = W'(dft_bin(xr, xi, k, 1'b1));
            exp_q.push_back({(k == N - 1), STAGES'(k),
                             W'(scale_ref(int'(br))), W'(scale_ref(int'(bi)))});
        end
        fr_re.delete();
        fr_im.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", bus.in_ready, 1'b0);
            check("rst_out_valid", bus.out_valid, 1'b0);
            exp_q.delete();
            fr_re.delete();
            fr_im.delete();
            m_frames    = 0;
            m_started   = 1'b0;
            m_last_xfer = -10;
        end else begin
            check("in_ready", bus.in_ready, m_started && (exp_q.size() == 0));
            check("busy", busy, exp_q.size() != 0);
            check("out_valid", bus.out_valid, (exp_q.size() != 0) && (cyc >= m_out_start));
            check("frames_done", frames_done, 16'(m_frames));
            if (bus.out_valid && exp_q.size() != 0) begin
                check("bin", {bus.out_last, bus.out_index, bus.out_real, bus.out_im}, exp_q[0]);
                if (bus.out_ready) begin
                    n_xfer++;
                    if (bus.out_index == '0) last_bin0 = int'(bus.out_real);
                    if (exp_q[0][EXP_W-1]) begin
                        m_frames++;
                        m_last_xfer = cyc;
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (fr_re.size() == 0) check("frame_gap", cyc > m_last_xfer, 1'b1);
                fr_re.push_back(bus.in_real);
                fr_im.push_back(bus.in_im);
                if (fr_re.size() == N) begin
                    build_expected();
                    m_out_start = cyc + FFT_LAT + 2;
                end
            end
            m_started = 1'b1;
        end
    end

    // ---------------- drivers ----------------
    int rdy_mode = 0;  // 0: always ready, 1: pattern 1,0,0,1, 2: random

    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
            ph++;
        end
    end

    // kind 0: impulse, 1: DC, 2: random. Leaves in_valid high on return.
    task automatic send_samples(input int kind, input int count, input bit gapped);
        int      t;
        bit      acc;
        sample_t re, im;
        for (int i = 0; i < count; i++) begin
            case (kind)
                0: begin re = (i == 0) ? sample_t'(1 << FRACTION) : '0; im = '0; end
                1: begin re = sample_t'(1 << FRACTION); im = '0; end
                default: begin
                    re = sample_t'(int'($urandom_range(0, 400)) - 200);
                    im = sample_t'(int'($urandom_range(0, 400)) - 200);
                end
            endcase
            bus.in_real  = re;
            bus.in_im    = im;
            bus.in_valid = 1'b1;
            t   = 0;
            acc = 1'b0;
            while (!acc && t < LIMIT) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) check("accept_timeout", t, 0);
            if (gapped && (i % 2 == 1)) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check("drain", t < LIMIT, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int x0;
        int dc0, imp0;
`ifdef FFT_FRAME_CTRL_SCALE_EN
        dc0  = 256;
        imp0 = 16;
`else
        dc0  = 4096;
        imp0 = 256;
`endif
        bus.in_valid = 1'b0;
        bus.in_real  = '0;
        bus.in_im    = '0;

        repeat (3) @(negedge clk);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out_last", bus.out_last, 1'b0);
        check("reset_out_index", bus.out_index, '0);
        check("reset_out_real", bus.out_real, '0);
        check("reset_out_im", bus.out_im, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_frames", frames_done, 16'd0);
        check("reset_state", state_dbg, LOAD);
        check("reset_x0", fft_x_real[0], '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // impulse, always ready
        send_samples(0, N, 1'b0);
        bus.in_valid = 1'b0;
        wait_idle();
        check("impulse_frames", frames_done, 16'd1);
        check("impulse_bin0", last_bin0, imp0);

        // DC, always ready
        send_samples(1, N, 1'b0);
        bus.in_valid = 1'b0;
        wait_idle();
        check("dc_bin0", last_bin0, dc0);
        check("dc_frames", frames_done, 16'd2);

        // DC with backpressure 1,0,0,1
        rdy_mode = 1;
        x0 = n_xfer;
        send_samples(1, N, 1'b0);
        bus.in_valid = 1'b0;
        wait_idle();
        check("bp_xfers", n_xfer - x0, N);
        check("bp_bin0", last_bin0, dc0);

        // random data with input gaps and random sink stalls
        rdy_mode = 2;
        send_samples(2, N, 1'b1);
        bus.in_valid = 1'b0;
        wait_idle();
        check("gap_frames", frames_done, 16'd4);

        // reset after 7 samples of a frame
        rdy_mode = 0;
        send_samples(2, 7, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < N; i++) begin
            check("rst_clr_x_real", fft_x_real[i], '0);
            check("rst_clr_x_im", fft_x_im[i], '0);
        end
        check("rst_mid_frames", frames_done, 16'd0);
        check("rst_mid_state", state_dbg, LOAD);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_samples(0, N, 1'b0);
        bus.in_valid = 1'b0;
        wait_idle();
        check("post_rst_frames", frames_done, 16'd1);
        check("post_rst_bin0", last_bin0, imp0);

        // three frames back to back; in_valid stays high through COMPUTE/UNLOAD
        rdy_mode = 2;
        for (int f = 0; f < 3; f++) send_samples(2, N, 1'b0);
        bus.in_valid = 1'b0;
        wait_idle();
        check("b2b_frames", frames_done, 16'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
